// File: rtl/npu_mem_loader.sv
// npu_mem_loader: turns a host byte stream into write-port traffic for the NPU
// memories (four striped image banks, conv, dense and denseb parameter RAMs).
//
// A load is armed with a one-cycle start carrying region/length. Bytes are then
// taken through a valid/ready handshake. Each accepted byte is presented as one
// registered write on the cycle after it is accepted.
//
// Ports
//   clk, reset        system clock, synchronous active-low reset
//   start             one-cycle pulse that begins a load (only honoured in IDLE)
//   region[1:0]       0=image, 1=conv, 2=dense, 3=denseb
//   length[15:0]      byte count of the load
//   in_data/in_valid  byte stream from the host
//   in_ready          loader accepts a byte this cycle
//   image_ram_addr_a  shared image bank address; data_image0..3 / we_image0..3
//   conv/dense/denseb _ram_addr_a, data_*, we_*   parameter RAM write ports
//   busy              load in progress (LOAD and FINISH)
//   done              one-cycle completion pulse
//   err               one-cycle pulse for a rejected start
//   checksum[15:0]    only with LOADER_CHECKSUM_EN: mod-2^16 sum of the bytes
//                     accepted in the current/last load
//
// Build option: define LOADER_CHECKSUM_EN to add the checksum port.

module npu_mem_loader #(
   parameter int unsigned IMG_BANK_DEPTH = 1024,
   parameter int unsigned PARAM_DEPTH    = 32768
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  region,
   input  logic [15:0] length,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [9:0]  image_ram_addr_a,
   output logic [7:0]  data_image0,
   output logic [7:0]  data_image1,
   output logic [7:0]  data_image2,
   output logic [7:0]  data_image3,
   output logic        we_image0,
   output logic        we_image1,
   output logic        we_image2,
   output logic        we_image3,
   output logic [14:0] conv_ram_addr_a,
   output logic [14:0] dense_ram_addr_a,
   output logic [14:0] denseb_ram_addr_a,
   output logic [7:0]  data_conv,
   output logic [7:0]  data_dense,
   output logic [7:0]  data_denseb,
   output logic        we_conv,
   output logic        we_dense,
   output logic        we_denseb,
   output logic        busy,
   output logic        done,
   output logic        err
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [15:0] checksum
`endif
);

   localparam int unsigned LEN_W   = 16;
   localparam int unsigned CAP_W   = LEN_W + 1;
   localparam logic [CAP_W-1:0] IMG_CAP = CAP_W'(4 * IMG_BANK_DEPTH);
   localparam logic [CAP_W-1:0] PRM_CAP = CAP_W'(PARAM_DEPTH);

   localparam logic [1:0] REG_IMAGE  = 2'd0;
   localparam logic [1:0] REG_CONV   = 2'd1;
   localparam logic [1:0] REG_DENSE  = 2'd2;
   localparam logic [1:0] REG_DENSEB = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   state_e               state_q;
   logic [LEN_W-1:0]     k_q;
   logic [LEN_W-1:0]     len_q;
   logic [1:0]           region_q;
   logic                 in_ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;

   logic [9:0]           img_addr_q;
   logic [3:0][7:0]      img_data_q;
   logic [3:0]           img_we_q;
   logic [14:0]          conv_addr_q;
   logic [14:0]          dense_addr_q;
   logic [14:0]          denseb_addr_q;
   logic [7:0]           conv_data_q;
   logic [7:0]           dense_data_q;
   logic [7:0]           denseb_data_q;
   logic                 conv_we_q;
   logic                 dense_we_q;
   logic                 denseb_we_q;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]          cs_q;
`endif

   logic [CAP_W-1:0]     cap_c;
   logic                 start_ok_c;
   logic                 accept_c;
   logic                 last_c;
   logic [LEN_W-1:0]     k_d;

   // Start qualification and handshake decode
   always_comb begin
      cap_c      = (region == REG_IMAGE) ? IMG_CAP : PRM_CAP;
      start_ok_c = (length != '0) && ({1'b0, length} <= cap_c);
      accept_c   = (state_q == ST_LOAD) && in_ready_q && in_valid;
      k_d        = k_q + LEN_W'(1);
      // k_d == len_q means the byte being accepted is the final one
      last_c     = (k_d == len_q);
   end

   // Load sequencer with registered write ports
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         k_q           <= '0;
         len_q         <= '0;
         region_q      <= '0;
         in_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         img_addr_q    <= '0;
         img_data_q    <= '0;
         img_we_q      <= '0;
         conv_addr_q   <= '0;
         dense_addr_q  <= '0;
         denseb_addr_q <= '0;
         conv_data_q   <= '0;
         dense_data_q  <= '0;
         denseb_data_q <= '0;
         conv_we_q     <= 1'b0;
         dense_we_q    <= 1'b0;
         denseb_we_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         cs_q          <= '0;
`endif
      end else begin
         // Pulses and write enables last a single cycle
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         img_we_q    <= '0;
         conv_we_q   <= 1'b0;
         dense_we_q  <= 1'b0;
         denseb_we_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  region_q <= region;
                  len_q    <= length;
                  if (start_ok_c) begin
                     state_q    <= ST_LOAD;
                     k_q        <= '0;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                     cs_q       <= '0;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               if (accept_c) begin
                  k_q <= k_d;
`ifdef LOADER_CHECKSUM_EN
                  cs_q <= cs_q + 16'(in_data);
`endif
                  case (region_q)
                     // Image bytes stripe across banks; address advances every 4 bytes
                     REG_IMAGE: begin
                        img_addr_q             <= k_q[11:2];
                        img_data_q[k_q[1:0]]   <= in_data;
                        img_we_q[k_q[1:0]]     <= 1'b1;
                     end
                     REG_CONV: begin
                        conv_addr_q <= k_q[14:0];
                        conv_data_q <= in_data;
                        conv_we_q   <= 1'b1;
                     end
                     REG_DENSE: begin
                        dense_addr_q <= k_q[14:0];
                        dense_data_q <= in_data;
                        dense_we_q   <= 1'b1;
                     end
                     default: begin
                        denseb_addr_q <= k_q[14:0];
                        denseb_data_q <= in_data;
                        denseb_we_q   <= 1'b1;
                     end
                  endcase
                  if (last_c) begin
                     in_ready_q <= 1'b0;
                     state_q    <= ST_FINISH;
                  end
               end
            end

            // Final write is on the ports this cycle; completion follows
            ST_FINISH: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end

            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready          = in_ready_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign err               = err_q;
   assign image_ram_addr_a  = img_addr_q;
   assign data_image0       = img_data_q[0];
   assign data_image1       = img_data_q[1];
   assign data_image2       = img_data_q[2];
   assign data_image3       = img_data_q[3];
   assign we_image0         = img_we_q[0];
   assign we_image1         = img_we_q[1];
   assign we_image2         = img_we_q[2];
   assign we_image3         = img_we_q[3];
   assign conv_ram_addr_a   = conv_addr_q;
   assign dense_ram_addr_a  = dense_addr_q;
   assign denseb_ram_addr_a = denseb_addr_q;
   assign data_conv         = conv_data_q;
   assign data_dense        = dense_data_q;
   assign data_denseb       = denseb_data_q;
   assign we_conv           = conv_we_q;
   assign we_dense          = dense_we_q;
   assign we_denseb         = denseb_we_q;
`ifdef LOADER_CHECKSUM_EN
   assign checksum          = cs_q;
`endif

endmodule

// File: tb/tb_npu_mem_loader.sv
// Testbench for npu_mem_loader. Every write seen on the memory ports is logged
// and compared against the write list derived from region/length/byte stream:
// byte i of an image load lands in bank i%4 at address i/4, byte i of any other
// region lands at address i of that RAM.

module tb_npu_mem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  region;
   logic [15:0] length;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  image_ram_addr_a;
   logic [7:0]  data_image0, data_image1, data_image2, data_image3;
   logic        we_image0, we_image1, we_image2, we_image3;
   logic [14:0] conv_ram_addr_a, dense_ram_addr_a, denseb_ram_addr_a;
   logic [7:0]  data_conv, data_dense, data_denseb;
   logic        we_conv, we_dense, we_denseb;
   logic        busy, done, err;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   npu_mem_loader dut (
      .clk(clk), .reset(reset), .start(start), .region(region), .length(length),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .image_ram_addr_a(image_ram_addr_a),
      .data_image0(data_image0), .data_image1(data_image1),
      .data_image2(data_image2), .data_image3(data_image3),
      .we_image0(we_image0), .we_image1(we_image1),
      .we_image2(we_image2), .we_image3(we_image3),
      .conv_ram_addr_a(conv_ram_addr_a), .dense_ram_addr_a(dense_ram_addr_a),
      .denseb_ram_addr_a(denseb_ram_addr_a),
      .data_conv(data_conv), .data_dense(data_dense), .data_denseb(data_denseb),
      .we_conv(we_conv), .we_dense(we_dense), .we_denseb(we_denseb),
      .busy(busy), .done(done), .err(err)
`ifdef LOADER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int unsigned cyc = 0;

   // target: 0..3 image banks, 4 conv, 5 dense, 6 denseb
   typedef struct {
      int          tgt;
      int          addr;
      int          data;
      int unsigned cyc;
   } wr_t;

   wr_t         wq[$];
   int unsigned done_cyc[$];
   int          err_seen;
   int          multi_viol;
   int          busy_at_done;
   logic [7:0]  stim[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void log_wr(input int t, input int a, input int d);
      wr_t w;
      w.tgt = t; w.addr = a; w.data = d; w.cyc = cyc;
      wq.push_back(w);
   endfunction

   // Write/pulse monitor, sampled mid-cycle
   always @(negedge clk) begin
      int n;
      n = 0;
      if (we_image0) begin log_wr(0, int'(image_ram_addr_a), int'(data_image0)); n++; end
      if (we_image1) begin log_wr(1, int'(image_ram_addr_a), int'(data_image1)); n++; end
      if (we_image2) begin log_wr(2, int'(image_ram_addr_a), int'(data_image2)); n++; end
      if (we_image3) begin log_wr(3, int'(image_ram_addr_a), int'(data_image3)); n++; end
      if (we_conv)   begin log_wr(4, int'(conv_ram_addr_a),   int'(data_conv));   n++; end
      if (we_dense)  begin log_wr(5, int'(dense_ram_addr_a),  int'(data_dense));  n++; end
      if (we_denseb) begin log_wr(6, int'(denseb_ram_addr_a), int'(data_denseb)); n++; end
      if (n > 1) multi_viol++;
      if (done) begin
         done_cyc.push_back(cyc);
         if (busy) busy_at_done++;
      end
      if (err) err_seen++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wq.delete();
      done_cyc.delete();
      err_seen     = 0;
      multi_viol   = 0;
      busy_at_done = 0;
   endtask

   function automatic logic any_out();
      return |{in_ready, busy, done, err, image_ram_addr_a,
               data_image0, data_image1, data_image2, data_image3,
               we_image0, we_image1, we_image2, we_image3,
               conv_ram_addr_a, dense_ram_addr_a, denseb_ram_addr_a,
               data_conv, data_dense, data_denseb, we_conv, we_dense, we_denseb};
   endfunction

   // mode: 0 in_valid held high, 1 alternating 1,0,1..., 2 random gaps
   task automatic run_load(input int r, input int mode, input bit poke, input string name);
      int L, idx, t, budget, bad, first_bad, nc;
      int exp_v, act_v, first_exp, first_act;
      bit v, acc;
      logic [15:0] sum;
      L = stim.size();
      clear_mon();
      region = 2'(r); length = 16'(L); start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, " busy/ready after start"}, {30'd0, busy, in_ready}, 32'd3);
`ifdef LOADER_CHECKSUM_EN
      chk({name, " checksum cleared"}, {16'd0, checksum}, 32'd0);
`endif
      idx = 0; t = 0; budget = L * 4 + 50;
      while (idx < L && t < budget) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (t % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         in_valid = v;
         in_data  = stim[idx];
         if (poke && t == 2) begin start = 1'b1; region = 2'd0; length = 16'd2; end
         else start = 1'b0;
         acc = v && in_ready;
         tick();
         t++;
         if (acc) idx++;
      end
      start = 1'b0;
      // Junk offered after the last byte must not be consumed
      in_valid = 1'b1; in_data = 8'hEE;
      t = 0;
      while (done_cyc.size() == 0 && t < 20) begin tick(); t++; end
      in_valid = 1'b0;
      tick(); tick();
      chk({name, " bytes accepted"}, 32'(idx), 32'(L));
      chk({name, " write count"}, 32'(wq.size()), 32'(L));
      bad = 0; first_bad = -1; first_exp = 0; first_act = 0; sum = 16'd0;
      for (int i = 0; i < L; i++) begin
         sum = sum + 16'(stim[i]);
         if (r == 0) exp_v = ((i % 4) << 24) | ((i / 4) << 8) | int'(stim[i]);
         else        exp_v = ((3 + r) << 24) | (i << 8) | int'(stim[i]);
         if (i < wq.size()) act_v = (wq[i].tgt << 24) | (wq[i].addr << 8) | wq[i].data;
         else               act_v = -1;
         if (act_v != exp_v) begin
            if (first_bad < 0) begin first_bad = i; first_exp = exp_v; first_act = act_v; end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s writes: %0d wrong, first #%0d got tgt/addr/data 0x%0h expected 0x%0h",
                  name, bad, first_bad, first_act, first_exp);
      end
      if (mode == 0) begin
         nc = 0;
         for (int i = 1; i < wq.size(); i++) if (wq[i].cyc != wq[i-1].cyc + 1) nc++;
         chk({name, " non-consecutive writes"}, 32'(nc), 32'd0);
      end
      chk({name, " done pulses"}, 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0 && wq.size() > 0)
         chk({name, " done cycle after last write"}, 32'(done_cyc[0] - wq[wq.size()-1].cyc), 32'd1);
      chk({name, " busy during done"}, 32'(busy_at_done), 32'd0);
      chk({name, " multiple we"}, 32'(multi_viol), 32'd0);
      chk({name, " spurious err"}, 32'(err_seen), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      chk({name, " checksum"}, {16'd0, checksum}, {16'd0, sum});
`endif
   endtask

   task automatic reject_seq(input int r, input int L, input string name);
      clear_mon();
      region = 2'(r); length = 16'(L); start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, " err pulse"}, {31'd0, err}, 32'd1);
      chk({name, " busy/ready"}, {30'd0, busy, in_ready}, 32'd0);
      tick();
      chk({name, " err single cycle"}, {31'd0, err}, 32'd0);
      tick(); tick();
      chk({name, " writes"}, 32'(wq.size()), 32'd0);
      chk({name, " done"}, 32'(done_cyc.size()), 32'd0);
   endtask

   typedef struct {
      int r;
      int len;
      bit exp_err;
      int mode;
      int last_addr;
   } vec_t;

   initial begin
      vec_t tbl[8];
      int   idx, t;
      bit   acc;

      tbl[0] = '{0, 4097,  1, 0, 0};
      tbl[1] = '{0, 0,     1, 0, 0};
      tbl[2] = '{2, 0,     1, 0, 0};
      tbl[3] = '{1, 32769, 1, 0, 0};
      tbl[4] = '{3, 65535, 1, 0, 0};
      tbl[5] = '{0, 4096,  0, 0, 1023};
      tbl[6] = '{3, 32768, 0, 0, 32767};
      tbl[7] = '{1, 1,     0, 2, 0};

      reset = 1'b0; start = 1'b0; region = '0; length = '0; in_data = '0; in_valid = 1'b0;
      tick(); tick(); tick();
      chk("reset outputs zero", {31'd0, any_out()}, 32'd0);
      reset = 1'b1;
      tick();

      // Image striping, full throughput
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(8'(8'h10 + i));
      run_load(0, 0, 1'b0, "image8");

      // conv with in_valid toggling
      stim.delete();
      stim.push_back(8'hA1); stim.push_back(8'hB2); stim.push_back(8'hC3);
      run_load(1, 1, 1'b0, "conv_toggle");

      // start re-pulsed in the middle of a dense load
      stim.delete();
      for (int i = 0; i < 5; i++) stim.push_back(8'($urandom));
      run_load(2, 0, 1'b1, "dense_restart");

      // Table of boundary starts
      for (int v = 0; v < 8; v++) begin
         if (tbl[v].exp_err) begin
            reject_seq(tbl[v].r, tbl[v].len, $sformatf("tbl%0d reject", v));
         end else begin
            stim.delete();
            for (int i = 0; i < tbl[v].len; i++) stim.push_back(8'($urandom));
            run_load(tbl[v].r, tbl[v].mode, 1'b0, $sformatf("tbl%0d load", v));
            if (wq.size() > 0)
               chk($sformatf("tbl%0d last addr", v), 32'(wq[wq.size()-1].addr), 32'(tbl[v].last_addr));
         end
      end

      // Reset after 2 of 6 bytes, then a fresh load
      clear_mon();
      region = 2'd1; length = 16'd6; start = 1'b1;
      tick();
      start = 1'b0;
      idx = 0; t = 0; in_valid = 1'b1;
      while (idx < 2 && t < 20) begin
         in_data = 8'(8'h30 + idx);
         acc = in_ready;
         tick(); t++;
         if (acc) idx++;
      end
      chk("pre-reset accepts", 32'(idx), 32'd2);
      in_valid = 1'b0; reset = 1'b0;
      tick();
      chk("mid-load reset outputs zero", {31'd0, any_out()}, 32'd0);
      reset = 1'b1;
      tick();
      chk("idle after reset", {30'd0, busy, in_ready}, 32'd0);
      stim.delete();
      stim.push_back(8'h5A); stim.push_back(8'hC3);
      run_load(1, 0, 1'b0, "post_reset");

`ifdef LOADER_CHECKSUM_EN
      stim.delete();
      for (int i = 0; i < 4; i++) stim.push_back(8'hFF);
      run_load(2, 0, 1'b0, "cksum_ff");
      chk("checksum 4xFF", {16'd0, checksum}, 32'h03FC);
      stim.delete();
      stim.push_back(8'h01);
      run_load(3, 0, 1'b0, "cksum_next");
`endif

      // Randomised loads against the write-list model
      for (int n = 0; n < 12; n++) begin
         stim.delete();
         t = $urandom_range(1, 40);
         for (int i = 0; i < t; i++) stim.push_back(8'($urandom));
         run_load($urandom_range(0, 3), 2, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
